// File: rtl/sha512_msg_ctrl.sv
// Message sequencer for the SHA-512 chunk core: loads the IV, restarts the core per chunk, chains H.
// Latency: accept -> LOAD (1) -> RUN until core_done -> digest_valid the cycle after the last chunk's done.
// Backpressure: in_ready only in IDLE; the digest holds until digest_ready, blocking the next chunk.
module sha512_msg_ctrl #(
    parameter int TIMEOUT = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_chunk,
    input  logic          in_last,
    output logic          digest_valid,
    input  logic          digest_ready,
    output logic [511:0]  digest,
    output logic          error,
    output logic [15:0]   chunk_count,
    output logic          core_reset_n,
    output logic [1023:0] core_chunk,
    output logic [511:0]  core_h_in,
    input  logic [511:0]  core_h_out,
    input  logic          core_done
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [511:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DIGEST} state_t;

    state_t         state;
    state_t         state_d;
    logic           first;
    logic           last_q;
    logic [WDW-1:0] wd;
    logic           accept;
    logic           done_ok;
    logic           expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // core_done outside RUN is ignored; done on the expiry cycle wins over the watchdog.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        done_ok = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (core_done) begin
                    done_ok = 1'b1;
                    state_d = last_q ? DIGEST : IDLE;
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            DIGEST: begin
                if (digest_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first        <= 1'b1;
            last_q       <= 1'b0;
            wd           <= '0;
            in_ready     <= 1'b0;
            core_reset_n <= 1'b0;
            core_chunk   <= '0;
            core_h_in    <= '0;
            chunk_count  <= '0;
            error        <= 1'b0;
        end else begin
            // Registered so the core reset is glitch-free and in_ready stays low
            // for the cycle after reset release.
            in_ready     <= (state_d == IDLE);
            core_reset_n <= (state_d != LOAD);
            wd           <= (state == RUN) ? wd + WDW'(1) : '0;

            if (accept) begin
                core_chunk <= in_chunk;
                last_q     <= in_last;
                if (first) begin
                    core_h_in   <= IV;
                    chunk_count <= '0;
                    error       <= 1'b0;
                    first       <= 1'b0;
                end
            end

            if (done_ok) begin
                core_h_in <= core_h_out;
                if (chunk_count != 16'hFFFF) begin
                    chunk_count <= chunk_count + 16'd1;
                end
            end

            // A timed-out message is abandoned; the next chunk restarts from the IV.
            if (expire) begin
                error <= 1'b1;
                first <= 1'b1;
            end

            if (state == DIGEST && digest_ready) begin
                first <= 1'b1;
            end
        end
    end

    assign digest_valid = (state == DIGEST);
    assign digest       = (state == DIGEST) ? core_h_in : '0;

endmodule

// File: tb/tb_sha512_msg_ctrl.sv
// Bench for sha512_msg_ctrl with a stub core of programmable latency and a toy compression function.
module tb_sha512_msg_ctrl;

    localparam int TO = 300;
    localparam int CORE_LAT = 242;

    localparam logic [511:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1023:0] in_chunk = '0;
    logic          in_last = 1'b0;
    logic          digest_valid;
    logic          digest_ready = 1'b0;
    logic [511:0]  digest;
    logic          error;
    logic [15:0]   chunk_count;
    logic          core_reset_n;
    logic [1023:0] core_chunk;
    logic [511:0]  core_h_in;
    logic [511:0]  core_h_out;
    logic          core_done;

    int n_checks = 0;
    int n_fail = 0;
    int core_lat = CORE_LAT;
    int core_cnt = 0;

    always #5 clk = ~clk;

    sha512_msg_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_chunk     (in_chunk),
        .in_last      (in_last),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest),
        .error        (error),
        .chunk_count  (chunk_count),
        .core_reset_n (core_reset_n),
        .core_chunk   (core_chunk),
        .core_h_in    (core_h_in),
        .core_h_out   (core_h_out),
        .core_done    (core_done)
    );

    // Toy per-chunk compression: each H word absorbs two chunk words, mod 2^64.
    function automatic logic [511:0] toy(input logic [511:0] h, input logic [1023:0] c);
        logic [511:0] o;
        logic [63:0]  a;
        logic [63:0]  b;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            a = c[1023 - 128*i -: 64];
            b = c[959 - 128*i -: 64];
            o[511 - 64*i -: 64] = h[511 - 64*i -: 64] + (a ^ {b[62:0], b[63]}) + 64'(i + 1);
        end
        return o;
    endfunction

    function automatic logic [1023:0] rand_chunk();
        logic [1023:0] c;
        for (int i = 0; i < 32; i++) c[32*i +: 32] = $urandom;
        return c;
    endfunction

    // Stub core: counts cycles since its reset released, done once the count reaches core_lat.
    always @(posedge clk) begin
        if (!core_reset_n) core_cnt <= 0;
        else               core_cnt <= core_cnt + 1;
    end
    assign core_done  = core_reset_n && (core_cnt >= core_lat);
    assign core_h_out = toy(core_h_in, core_chunk);

    // Offers one chunk, returns at the negedge of the LOAD cycle after checking what was loaded.
    task automatic send(input logic [1023:0] c, input logic l, input logic [511:0] hexp);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1 within 2000 cycles", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_chunk = c;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (core_h_in !== hexp) begin
            n_fail++;
            $display("FAIL load_h_in: got %h required %h", core_h_in, hexp);
        end
        n_checks++;
        if (core_chunk !== c) begin
            n_fail++;
            $display("FAIL load_chunk: got %h required %h", core_chunk, c);
        end
        n_checks++;
        if ({core_reset_n, in_ready, digest_valid, digest} !== {1'b0, 1'b0, 1'b0, 512'd0}) begin
            n_fail++;
            $display("FAIL load_ctrl: core_reset_n=%b in_ready=%b digest_valid=%b digest=%h required 0,0,0,0",
                     core_reset_n, in_ready, digest_valid, digest);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1 || digest_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk_return: in_ready=%b digest_valid=%b required 1,0", in_ready, digest_valid);
        end
    endtask

    // Called at the LOAD negedge (k=0); k counts posedges since the accept edge.
    task automatic wait_digest(input logic [511:0] dexp, input int cnt, input int lat, input int hold);
        int k;
        logic [1023:0] junk;
        k = 0;
        while (!digest_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (digest_valid !== 1'b1 || k != lat) begin
            n_fail++;
            $display("FAIL digest_latency: valid=%b after %0d cycles, required 1 after %0d", digest_valid, k, lat);
        end
        n_checks++;
        if (digest !== dexp) begin
            n_fail++;
            $display("FAIL digest_value: got %h required %h", digest, dexp);
        end
        n_checks++;
        if (chunk_count !== 16'(cnt) || error !== 1'b0) begin
            n_fail++;
            $display("FAIL digest_status: chunk_count=%0d error=%b required %0d,0", chunk_count, error, cnt);
        end
        junk = rand_chunk();
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_chunk = junk;
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || digest_valid !== 1'b1 || digest !== dexp) begin
                n_fail++;
                $display("FAIL digest_hold[%0d]: in_ready=%b valid=%b digest=%h required 0,1,%h",
                         i, in_ready, digest_valid, digest, dexp);
            end
        end
        in_valid = 1'b0;
        digest_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready = 1'b0;
        n_checks++;
        if (digest_valid !== 1'b0 || digest !== 512'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL digest_release: valid=%b digest=%h in_ready=%b required 0,0,1",
                     digest_valid, digest, in_ready);
        end
    endtask

    // Reference: digest is the toy compression folded over the chunks, starting from the IV.
    task automatic run_msg(input int nchunks, input int lat, input int hold);
        logic [511:0]  h;
        logic [1023:0] c;
        h = IV;
        for (int j = 0; j < nchunks; j++) begin
            c = rand_chunk();
            send(c, (j == nchunks - 1), h);
            h = toy(h, c);
            if (j != nchunks - 1) wait_idle();
        end
        wait_digest(h, nchunks, lat, hold);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, digest_valid, error, core_reset_n} !== 4'b0000 || digest !== 512'd0 ||
            chunk_count !== 16'd0 || core_chunk !== 1024'd0 || core_h_in !== 512'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b dv=%b err=%b crn=%b cnt=%0d dig=%h required all 0",
                     in_ready, digest_valid, error, core_reset_n, chunk_count, digest);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (core_reset_n !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: core_reset_n=%b in_ready=%b required 1,1", core_reset_n, in_ready);
        end
    endtask

    task automatic test_single();
        core_lat = CORE_LAT;
        for (int i = 0; i < 3; i++) run_msg(1, CORE_LAT + 2, 0);
    endtask

    task automatic test_multi();
        core_lat = CORE_LAT;
        run_msg(2, CORE_LAT + 2, 0);
        run_msg(int'($urandom_range(3, 4)), CORE_LAT + 2, 0);
    endtask

    task automatic test_back_to_back();
        core_lat = CORE_LAT;
        run_msg(1, CORE_LAT + 2, 10);
        run_msg(1, CORE_LAT + 2, 0);
    endtask

    task automatic test_timeout();
        logic [1023:0] c;
        core_lat = 1 << 30;
        c = rand_chunk();
        send(c, 1'b1, IV);
        repeat (TO) @(negedge clk);
        n_checks++;
        if (error !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: error=%b in_ready=%b required 0,0", error, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || in_ready !== 1'b1 || digest_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag: error=%b in_ready=%b digest_valid=%b required 1,1,0",
                     error, in_ready, digest_valid);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: error=%b required 1", error);
        end
        core_lat = CORE_LAT;
        run_msg(1, CORE_LAT + 2, 0);
    endtask

    task automatic test_coincident();
        core_lat = TO - 1;
        run_msg(1, TO + 1, 0);
        core_lat = CORE_LAT;
    endtask

    task automatic test_reset_mid_run();
        logic [1023:0] c;
        core_lat = CORE_LAT;
        c = rand_chunk();
        send(c, 1'b1, IV);
        repeat (101) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, digest_valid, error, core_reset_n} !== 4'b0000 || digest !== 512'd0 ||
            chunk_count !== 16'd0 || core_chunk !== 1024'd0 || core_h_in !== 512'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b dv=%b err=%b crn=%b cnt=%0d h_in=%h required all 0",
                     in_ready, digest_valid, error, core_reset_n, chunk_count, core_h_in);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (core_reset_n !== 1'b1 || in_ready !== 1'b1 || digest_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_release: core_reset_n=%b in_ready=%b dv=%b required 1,1,0",
                     core_reset_n, in_ready, digest_valid);
        end
        run_msg(1, CORE_LAT + 2, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_timeout();
        test_coincident();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha512_msg_ctrl.md
# sha512_msg_ctrl

Message-level sequencer for the `sha512_chunk` compression core. Accepts a stream of pre-padded 1024-bit chunks over a valid/ready handshake and loads the SHA-512 IV for the first chunk of each message. It restarts the core once per chunk, waits for its `done`, chains the resulting H values into the next chunk, and presents the 512-bit digest after the chunk flagged `in_last`. A watchdog flags a core that never completes.

## Interface
Parameters:
- `TIMEOUT`, 512: maximum RUN cycles allowed per chunk before error; must exceed the core latency of 242 cycles.

Ports:
- `clk`  in  1  sole clock; all flops are on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  chunk offered.
- `in_ready`  out  1  controller can accept a chunk.
- `in_chunk`  in  1024  pre-padded chunk; byte 0 at [1023:1016].
- `in_last`  in  1  chunk is the final chunk of its message.
- `digest_valid`  out  1  digest available.
- `digest_ready`  in  1  consumer takes the digest.
- `digest`  out  512  {H0,H1,…,H7}; H0 at [511:448].
- `error`  out  1  sticky watchdog flag; cleared by `reset` or by the next accepted first chunk.
- `chunk_count`  out  16  chunks completed in the current message, saturating at 16'hFFFF.
- `core_reset_n`  out  1  drives the core's active-low reset.
- `core_chunk`  out  1024  registered chunk fed to the core.
- `core_h_in`  out  512  registered {H0i..H7i} fed to the core.
- `core_h_out`  in  512  {oH0..oH7} from the core.
- `core_done`  in  1  core finished the chunk.

## Operation
- States:
  - **IDLE**: `in_ready`=1.
    - On `in_valid`: capture `in_chunk` into `core_chunk` and `in_last` into `last_q`.
    - If the `first` flag is set, set `core_h_in` to the SHA-512 IV (6a09e667f3bcc908, bb67ae8584caa73b, 3c6ef372fe94f82b, a54ff53a5f1d36f1, 510e527fade682d1, 9b05688c2b3e6c1f, 1f83d9abfb41bd6b, 5be0cd19137e2179), clear `chunk_count`, clear `error`, and clear `first`.
    - Otherwise keep `core_h_in` as is. Go to LOAD.
  - **LOAD**: one cycle; `core_reset_n`=0; go to RUN.
  - **RUN**: `core_reset_n`=1; increment the watchdog counter each cycle.
    - When `core_done`=1: `core_h_in` <= `core_h_out`, `chunk_count` +1 (saturating), clear the watchdog.
    - Then go to DIGEST if `last_q`, else go to IDLE.
    - If the counter reaches `TIMEOUT` with no `core_done`: set `error`, set `first` (the message is discarded), and go to IDLE.
  - **DIGEST**: `digest_valid`=1 and `digest`=`core_h_in`. On `digest_ready`: set `first` and go to IDLE.
- `core_chunk` and `core_h_in` hold stable from LOAD through the cycle `core_done` is sampled, because the core's outputs are combinational on its H inputs.
- `core_reset_n` comes from a dedicated flop, not decoded logic. It is low during reset, during LOAD, and through the cycle after reset deasserts; it is high otherwise.
- `in_ready` is 0 in LOAD, RUN and DIGEST. The next chunk is never accepted while a digest is pending.
- H chaining is plain 64-bit modular arithmetic performed inside the core; the controller only registers the result.
- `digest` outputs 0 unless in DIGEST.

## Timing
- Reset values:
  - State IDLE, `first`=1.
  - `in_ready`=0 in the reset cycle, then 1 in IDLE.
  - `digest_valid`=0, `digest`=0, `error`=0, `chunk_count`=0, `core_reset_n`=0.
  - `core_chunk`=0, `core_h_in`=0.
- Accept edge E: LOAD occupies cycle E+1 and RUN starts at E+2.
- With the real core, `core_done` rises 242 cycles after RUN entry. Per-chunk throughput is therefore 1 (IDLE) + 1 (LOAD) + 243 (RUN) = 245 cycles.
- `digest_valid` rises the cycle after `core_done` is sampled for a last chunk. It holds until the handshake; the digest stays stable while waiting.
- A `core_done` that is already high on RUN entry does not occur, because LOAD reset the core. A `core_done` in any state other than RUN is ignored.
- `core_done` in the same cycle the watchdog expires counts as completion, with no error.
- `reset` asserted mid-RUN or mid-DIGEST: the next edge forces all reset values, the digest is lost, and the core is held in reset.
- `in_valid` while `in_ready`=0: no effect; the upstream holds its data.

## Test plan
- Single chunk "abc" (61626380…00, length field 0x18) with `in_last`=1:
  - `digest` = ddaf35a193617aba cc417349ae204131 12e6fa4e89a97ea2 0a9eeee64b55d39a 2192992a274fc1a8 36ba3c23a3feebbd 454d4423643ce80e 2a9ac94fa54ca49f.
  - `chunk_count`=1, and `digest_valid` rises 244 cycles after the accept edge.
- Two-chunk message (896-bit "abcdefgh…nopqrstu" vector) -> digest 8e959b75dae313da 8cf4f72814fc143f 8f7779c6eb9f7fa1 7299aeadb6889018 501d289e4900f7e4 331b99dec4b5433a c7d329eeb6dd2654 5e96e55b874be909, `chunk_count`=2, and the second chunk's `core_h_in` equals the first chunk's `core_h_out`.
- Back-to-back messages with `digest_ready` held low for 10 cycles -> `in_ready` stays 0 and the digest holds. After the handshake, the second message starts from the IV and produces the same "abc" digest.
- Stub core that never raises `core_done`, with `TIMEOUT`=16 -> `error`=1 exactly 16 cycles after RUN entry and the controller returns to IDLE. The next chunk clears `error` and hashes correctly from the IV.
- `reset` pulsed at RUN cycle 100 -> all outputs take their reset values the next cycle and `core_reset_n`=0. A fresh "abc" then yields the correct digest.
- Stub core with `core_done` coincident with watchdog expiry -> no error, and H is updated.
